// File: rtl/ddr_write_pack_buffer_pkg.sv
// Shared types and constants for the DDR write-side pack buffer.
// The length and address widths match the readback control path.
package ddr_wr_pkg;
  localparam int LEN_W      = 8;
  localparam int DDR_ADDR_W = 30;
  localparam int DDR_DATA_W = 32;
  localparam int WPB        = 8;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DATA, ST_WAIT_FIN} wr_state_e;
endpackage

// File: rtl/ddr_write_pack_buffer_if.sv
// Burst interface between the pack buffer (master) and the DDR write arbiter (slave).
interface ddr_write_pack_buffer_if #(
  parameter int ADDR_WIDTH    = 30,
  parameter int MEM_DATA_BITS = 256
);
  logic                         wr_ddr_req;
  logic [ddr_wr_pkg::LEN_W-1:0] wr_ddr_len;
  logic [ADDR_WIDTH-1:0]        wr_ddr_addr;
  logic                         wr_ddr_data_req;
  logic [MEM_DATA_BITS-1:0]     wr_ddr_data;
  logic                         wr_ddr_finish;

  modport master (
    output wr_ddr_req, wr_ddr_len, wr_ddr_addr, wr_ddr_data,
    input  wr_ddr_data_req, wr_ddr_finish
  );
  modport slave (
    input  wr_ddr_req, wr_ddr_len, wr_ddr_addr, wr_ddr_data,
    output wr_ddr_data_req, wr_ddr_finish
  );
endinterface

// File: rtl/ddr_write_pack_buffer_fifo.sv
// First-word-fall-through beat FIFO; dout always shows the head entry.
module wr_beat_fifo import ddr_wr_pkg::*; #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 64,
  localparam int AW   = log2c(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign push_ok = push && (count != DEPTH_C);
  assign pop_ok  = pop && (count != '0);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ddr_write_pack_buffer.sv
// Packs DATA_WIDTH words into DDR beats, buffers them and issues fixed-length
// write bursts; a last-word marker flushes a final partial burst and pulses done.
module ddr_write_pack_buffer import ddr_wr_pkg::*; #(
  parameter int ADDR_WIDTH    = DDR_ADDR_W,
  parameter int DATA_WIDTH    = DDR_DATA_W,
  parameter int MEM_DATA_BITS = DDR_DATA_W * WPB,
  parameter int BURST_LEN     = 32,
  parameter int FIFO_DEPTH    = 64
) (
  input  logic                    ddr_clk_i,
  input  logic                    ddr_rst_i,
  input  logic                    wr_start_i,
  input  logic [ADDR_WIDTH-1:0]   wr_start_addr_i,
  input  logic                    wr_vld_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    wr_last_i,
  output logic                    wr_ready_o,
  ddr_write_pack_buffer_if.master ddr,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overflow_o
);
  localparam int BW = MEM_DATA_BITS / DATA_WIDTH;
  localparam int IW = (log2c(BW) < 1) ? 1 : log2c(BW);
  localparam int CW = log2c(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]         BL_C     = CW'(BURST_LEN);
  localparam logic [CW-1:0]         FULL_C   = CW'(FIFO_DEPTH - 1);
  localparam logic [IW-1:0]         LAST_IDX = IW'(BW - 1);
  localparam logic [ADDR_WIDTH-1:0] BW_A     = ADDR_WIDTH'(BW);

  wr_state_e                state_q, state_d;
  logic [LEN_W-1:0]         len_q, len_d, beat_cnt_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic                     busy_q, flush_q, done_q, ovf_q;
  logic [MEM_DATA_BITS-1:0] pack_q, pack_next, push_data_q, fifo_dout;
  logic [IW-1:0]            idx_q;
  logic                     push_q, pop, fin, req, take;
  logic [CW-1:0]            fifo_count;

  wr_beat_fifo #(.WIDTH(MEM_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (ddr_clk_i),
    .rst  (ddr_rst_i),
    .push (push_q),
    .din  (push_data_q),
    .pop  (pop),
    .dout (fifo_dout),
    .count(fifo_count)
  );

  assign wr_ready_o      = (fifo_count < FULL_C) && !flush_q && busy_q;
  assign take            = wr_vld_i && wr_ready_o;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign overflow_o      = ovf_q;
  assign ddr.wr_ddr_req  = req;
  assign ddr.wr_ddr_len  = len_q;
  assign ddr.wr_ddr_addr = addr_q;
  assign ddr.wr_ddr_data = (state_q == ST_DATA) ? fifo_dout : '0;

  always_comb begin
    pack_next = pack_q;
    for (int k = 0; k < BW; k++)
      if (idx_q == IW'(k)) pack_next[k*DATA_WIDTH +: DATA_WIDTH] = wr_data_i;
  end

  // Flush bursts wait for the packer's registered push so the tail beat is counted.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    req     = 1'b0;
    pop     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      ST_IDLE:
        if (fifo_count >= BL_C) begin
          state_d = ST_REQ;
          len_d   = LEN_W'(BURST_LEN);
        end else if (flush_q && fifo_count != '0 && !push_q) begin
          state_d = ST_REQ;
          len_d   = LEN_W'(fifo_count);
        end
      ST_REQ: begin
        req     = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA:
        if (ddr.wr_ddr_finish) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end else if (ddr.wr_ddr_data_req) begin
          pop = 1'b1;
          if (beat_cnt_q == len_q - LEN_W'(1)) state_d = ST_WAIT_FIN;
        end
      ST_WAIT_FIN:
        if (ddr.wr_ddr_finish) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pack_q      <= '0;
      idx_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      done_q  <= 1'b0;
      push_q  <= 1'b0;
      if (state_q == ST_REQ) beat_cnt_q <= '0;
      else if (pop)          beat_cnt_q <= beat_cnt_q + LEN_W'(1);

      if (wr_start_i && !busy_q) begin
        addr_q <= wr_start_addr_i;
        busy_q <= 1'b1;
        pack_q <= '0;
        idx_q  <= '0;
      end else if (take) begin
        if (idx_q == LAST_IDX || wr_last_i) begin
          push_q      <= 1'b1;
          push_data_q <= pack_next;
          pack_q      <= '0;
          idx_q       <= '0;
          flush_q     <= flush_q | wr_last_i;
        end else begin
          pack_q <= pack_next;
          idx_q  <= idx_q + IW'(1);
        end
      end

      if (wr_vld_i && !wr_ready_o) ovf_q <= 1'b1;

      if (fin) begin
        addr_q <= addr_q + ADDR_WIDTH'(len_q) * BW_A;
        if (flush_q && fifo_count == '0 && !push_q) begin
          done_q  <= 1'b1;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      end
    end
  end
endmodule
